fft16_bfly_ctrl: RTL and testbench
==================================

Name: fft16_bfly_ctrl

Overview:
Sequencer for the 16-point radix-2 DIT FFT. It drives a single shared butterfly datapath and a dual-port working RAM.
- For each of the 4 stages it issues 8 butterfly operations. Each operation gets read addresses (A/B), a twiddle index and a delayed write-back strobe with matching write addresses.
- It inserts drain cycles between stages so that no read-after-write hazard occurs.
- A loader places input samples in bit-reversed order before start. The controller does not do this itself.

Parameters:
- RD_LAT, 1, cycles from rd_en to RAM read data valid at butterfly inputs.
- BF_LAT, 1, cycles through the butterfly/twiddle multiply to registered results. PIPE = RD_LAT + BF_LAT; legal PIPE range is 1..7.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a transform; sampled only in IDLE.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the final write-back has completed.
- stage  output  2  current stage, 0..3.
- rd_en  output  1  butterfly issue strobe / RAM read enable.
- rd_addr_a  output  4  RAM address of butterfly input A.
- rd_addr_b  output  4  RAM address of butterfly input B.
- tw_idx  output  3  twiddle index k for W16^k, 0..7.
- wr_en  output  1  write-back strobe for butterfly results.
- wr_addr_a  output  4  RAM address for result r1 (A + W·B).
- wr_addr_b  output  4  RAM address for result r2 (A − W·B).

Behaviour:
- Interface: one clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset: when rst is high at a clock edge, the block goes to IDLE and clears all outputs to 0 (busy, done, stage, rd_en, both rd addresses, tw_idx, wr_en, both wr addresses). The write-delay pipeline valid bits are cleared, so no pending writes survive.
- Reset mid-operation: the transform is abandoned. No wr_en or done follows.

State machine:
- IDLE: if start = 1, go to RUN with stage = 0 and bfly = 0. Otherwise stay.
- RUN: rd_en = 1 every cycle; bfly increments each cycle. After bfly = 7, go to DRAIN with drain counter = PIPE.
- DRAIN: rd_en = 0. Decrement the counter; when it reaches the last drain cycle:
  - if stage < 3: increment stage, set bfly = 0, return to RUN;
  - otherwise go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start: ignored outside IDLE. Asserting start again while in DONE does not restart; the next request must come in IDLE.

Address generation (stage s, butterfly k; outputs are registered and valid in the same cycle as rd_en):
- span = 2^s; grp = k >> s; pos = k & (span − 1).
- rd_addr_a = grp·2·span + pos; rd_addr_b = rd_addr_a + span.
- tw_idx = pos << (3 − s).
- Outputs hold their last values when rd_en = 0.

Write-back:
- wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly PIPE cycles, via a shift register.
- A write and a read may occur in the same cycle only within a stage; their addresses are then always disjoint.

Timing:
- Start accepted at cycle T. First rd_en is at T+1.
- Each stage takes 8 + PIPE cycles.
- Last read is at T+3(8+PIPE)+8. Last wr_en is PIPE cycles after that. done pulses on the following cycle.
- With PIPE = 2: last rd at T+38, last wr at T+40, done at T+41.
- stage changes only at the RUN entry cycle.

Test Plan:
- Reset with PIPE = 2: assert rst for 2 cycles, then start pulse at T → rd_en high T+1..T+8 and T+11..T+18; done only at T+41; busy high T+1..T+40.
- Address check, stage 0: pairs (0,1),(2,3)…(14,15) with tw_idx = 0. Stage 1: (0,2),(1,3),(4,6),(5,7)… with tw_idx 0,4,0,4… Stage 3: (k, k+8) with tw_idx = k.
- Write-back alignment: every wr_en pulse carries the same address pair as the rd_en pulse exactly PIPE cycles earlier; exactly 32 writes per transform; no read in stage s+1 precedes the last write of stage s.
- Start while busy: start pulse at T+5 and again at T+41 → no change to sequencing; one done only; a new transform begins only on a start sampled in IDLE at T+42 or later.
- Reset mid-operation: assert rst at T+15 for 1 cycle → all outputs are 0 from the next cycle; no wr_en afterwards; done never pulses; a subsequent start behaves as in the first scenario.
- Parameter sweep (PIPE = 1 and 7): done at T+4(8+PIPE)+1, i.e. T+37 and T+61.

Source files
------------

// File: rtl/fft16_bfly_ctrl.sv
// fft16_bfly_ctrl: sequencer for a 16-point radix-2 DIT FFT.
// Issues 8 butterflies per stage over 4 stages to one shared butterfly
// datapath, with a matching delayed write-back stream. Drain cycles between
// stages keep each stage's reads behind the previous stage's last write.
module fft16_bfly_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] stage,
  output logic       rd_en,
  output logic [3:0] rd_addr_a,
  output logic [3:0] rd_addr_b,
  output logic [2:0] tw_idx,
  output logic       wr_en,
  output logic [3:0] wr_addr_a,
  output logic [3:0] wr_addr_b
);

  localparam int unsigned PIPE     = RD_LAT + BF_LAT;
  localparam logic [2:0]  PIPE_CNT = 3'(PIPE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t     state, state_n;
  logic [2:0] bfly, bfly_n;
  logic [1:0] stg, stg_n;
  logic [2:0] dcnt, dcnt_n;
  logic [3:0] addr_a_n, addr_b_n;
  logic [2:0] tw_n;

  logic [PIPE-1:0] wv;
  logic [3:0]      wa_p [PIPE];
  logic [3:0]      wb_p [PIPE];

  // Butterfly addressing for stage s, butterfly k: {addr_a, addr_b, tw_idx}.
  function automatic logic [10:0] bfly_addr(input logic [1:0] s, input logic [2:0] k);
    logic [3:0] kk, span, pos, grp, a, b;
    logic [2:0] pos3, tw;
    kk   = {1'b0, k};
    span = 4'd1 << s;
    pos  = kk & (span - 4'd1);
    grp  = kk >> s;
    a    = ((grp << 1) << s) | pos;
    b    = a + span;
    pos3 = pos[2:0];
    tw   = pos3 << (2'd3 - s);
    return {a, b, tw};
  endfunction

  // Next-state logic for the stage/butterfly/drain sequencing.
  always_comb begin
    state_n = state;
    bfly_n  = bfly;
    stg_n   = stg;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          stg_n   = 2'd0;
          bfly_n  = 3'd0;
        end
      end
      RUN: begin
        if (bfly == 3'd7) begin
          state_n = DRAIN;
          dcnt_n  = PIPE_CNT;
        end else begin
          bfly_n = bfly + 3'd1;
        end
      end
      DRAIN: begin
        if (dcnt == 3'd1) begin
          if (stg != 2'd3) begin
            state_n = RUN;
            stg_n   = stg + 2'd1;
            bfly_n  = 3'd0;
          end else begin
            state_n = DONE;
          end
        end else begin
          dcnt_n = dcnt - 3'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Addresses for the butterfly about to be issued.
  always_comb begin
    {addr_a_n, addr_b_n, tw_n} = bfly_addr(stg_n, bfly_n);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bfly  <= '0;
      stg   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      bfly  <= bfly_n;
      stg   <= stg_n;
      dcnt  <= dcnt_n;
    end
  end

  assign stage = stg;

  // Registered status and read-side outputs, decoded from the next state so
  // they line up with the state register; addresses hold while not issuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
    end else begin
      busy  <= (state_n == RUN) || (state_n == DRAIN);
      done  <= (state_n == DONE);
      rd_en <= (state_n == RUN);
      if (state_n == RUN) begin
        rd_addr_a <= addr_a_n;
        rd_addr_b <= addr_b_n;
        tw_idx    <= tw_n;
      end
    end
  end

  // Write-back delay line: read strobe and addresses delayed by PIPE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wv <= '0;
      for (int unsigned i = 0; i < PIPE; i++) begin
        wa_p[i] <= '0;
        wb_p[i] <= '0;
      end
    end else begin
      wv[0]   <= rd_en;
      wa_p[0] <= rd_addr_a;
      wb_p[0] <= rd_addr_b;
      for (int unsigned i = 1; i < PIPE; i++) begin
        wv[i]   <= wv[i-1];
        wa_p[i] <= wa_p[i-1];
        wb_p[i] <= wb_p[i-1];
      end
    end
  end

  assign wr_en     = wv[PIPE-1];
  assign wr_addr_a = wa_p[PIPE-1];
  assign wr_addr_b = wb_p[PIPE-1];

endmodule

// File: tb/tb_fft16_bfly_ctrl.sv
// Testbench for fft16_bfly_ctrl: scoreboarded PIPE=2 instance plus
// PIPE=1 and PIPE=7 instances checked for status and write timing.
module tb_fft16_bfly_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_m, start_x;
  logic [2:0] busy_v, done_v, rd_v, wr_v;
  logic [1:0] st_v [3];
  logic [3:0] ra_v [3], rb_v [3], wa_v [3], wb_v [3];
  logic [2:0] tw_v [3];

  fft16_bfly_ctrl #(.RD_LAT(1), .BF_LAT(1)) u_p2 (
    .clk(clk), .rst(rst), .start(start_m), .busy(busy_v[0]), .done(done_v[0]),
    .stage(st_v[0]), .rd_en(rd_v[0]), .rd_addr_a(ra_v[0]), .rd_addr_b(rb_v[0]),
    .tw_idx(tw_v[0]), .wr_en(wr_v[0]), .wr_addr_a(wa_v[0]), .wr_addr_b(wb_v[0]));

  fft16_bfly_ctrl #(.RD_LAT(0), .BF_LAT(1)) u_p1 (
    .clk(clk), .rst(rst), .start(start_x), .busy(busy_v[1]), .done(done_v[1]),
    .stage(st_v[1]), .rd_en(rd_v[1]), .rd_addr_a(ra_v[1]), .rd_addr_b(rb_v[1]),
    .tw_idx(tw_v[1]), .wr_en(wr_v[1]), .wr_addr_a(wa_v[1]), .wr_addr_b(wb_v[1]));

  fft16_bfly_ctrl #(.RD_LAT(3), .BF_LAT(4)) u_p7 (
    .clk(clk), .rst(rst), .start(start_x), .busy(busy_v[2]), .done(done_v[2]),
    .stage(st_v[2]), .rd_en(rd_v[2]), .rd_addr_a(ra_v[2]), .rd_addr_b(rb_v[2]),
    .tw_idx(tw_v[2]), .wr_en(wr_v[2]), .wr_addr_a(wa_v[2]), .wr_addr_b(wb_v[2]));

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic [1:0] s;
  } rec_t;

  rec_t rdq [$];
  rec_t wrq [$];

  int   vec = 0;
  int   miscmp = 0;
  int   cyc = 0;
  bit   active [3];
  int   t0 [3];
  int   wcnt [3];
  logic [3:0] last_a, last_b;
  logic [2:0] last_tw;

  function automatic int pv(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
  endfunction

  // Read issued at transform offset d for pipeline depth p.
  function automatic bit is_rd(input int d, input int p);
    int len;
    len = 8 + p;
    if (d < 1 || d > 4 * len) return 1'b0;
    return ((d - 1) % len) < 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Start accepted for instance i in the current cycle: build its expectations.
  task automatic accept(input int i);
    int len, span, rc, a;
    rec_t r;
    active[i] = 1'b1;
    t0[i]     = cyc;
    wcnt[i]   = 0;
    if (i == 0) begin
      len = 8 + pv(0);
      for (int s = 0; s < 4; s++) begin
        span = 1 << s;
        for (int k = 0; k < 8; k++) begin
          a    = (k / span) * 2 * span + (k % span);
          rc   = cyc + 1 + s * len + k;
          r.cyc = rc;
          r.a   = 4'(a);
          r.b   = 4'(a + span);
          r.tw  = 3'((k % span) * (8 / span));
          r.s   = 2'(s);
          rdq.push_back(r);
          r.cyc = rc + pv(0);
          wrq.push_back(r);
        end
      end
    end
  endtask

  task automatic tick();
    int   p, len, d;
    bit   eb, ed, er, ew;
    rec_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      chk("rst_outputs", {busy_v[0], done_v[0], st_v[0], rd_v[0], ra_v[0], rb_v[0],
                          tw_v[0], wr_v[0], wa_v[0], wb_v[0]}, 0);
      chk("rst_sweep", {busy_v[2:1], done_v[2:1], wr_v[2:1], rd_v[2:1]}, 0);
      for (int i = 0; i < 3; i++) active[i] = 1'b0;
      rdq.delete();
      wrq.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        p   = pv(i);
        len = 8 + p;
        d   = cyc - t0[i];
        if (active[i] && d > 4 * len + 1) active[i] = 1'b0;
        eb = active[i] && d >= 1 && d <= 4 * len;
        ed = active[i] && d == 4 * len + 1;
        chk($sformatf("busy%0d", i), busy_v[i], eb);
        chk($sformatf("done%0d", i), done_v[i], ed);
        if (wr_v[i]) wcnt[i]++;
        if (ed) chk($sformatf("wrcount%0d", i), wcnt[i], 32);
        if (i > 0) begin
          er = active[i] && is_rd(d, p);
          ew = active[i] && is_rd(d - p, p);
          chk($sformatf("rd_en%0d", i), rd_v[i], er);
          chk($sformatf("wr_en%0d", i), wr_v[i], ew);
        end else begin
          er = (rdq.size() != 0) && (rdq[0].cyc == cyc);
          ew = (wrq.size() != 0) && (wrq[0].cyc == cyc);
          chk("rd_en", rd_v[0], er);
          chk("wr_en", wr_v[0], ew);
          if (eb) chk("stage", st_v[0], (d - 1) / len);
          if (er) begin
            r = rdq.pop_front();
            chk("rd_addr", {ra_v[0], rb_v[0], tw_v[0]}, {r.a, r.b, r.tw});
            last_a  = r.a;
            last_b  = r.b;
            last_tw = r.tw;
          end else if (eb) begin
            chk("rd_hold", {ra_v[0], rb_v[0], tw_v[0]}, {last_a, last_b, last_tw});
          end
          if (ew) begin
            r = wrq.pop_front();
            chk("wr_addr", {wa_v[0], wb_v[0]}, {r.a, r.b});
          end
        end
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse(input bit main);
    if (main) begin
      start_m = 1'b1;
      if (!active[0]) accept(0);
    end else begin
      start_x = 1'b1;
      if (!active[1]) accept(1);
      if (!active[2]) accept(2);
    end
    tick();
    start_m = 1'b0;
    start_x = 1'b0;
  endtask

  initial begin
    int t;
    rst     = 1'b1;
    start_m = 1'b0;
    start_x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      active[i] = 1'b0;
      t0[i]     = 0;
      wcnt[i]   = 0;
    end
    last_a  = '0;
    last_b  = '0;
    last_tw = '0;

    // Reset for two cycles, then idle.
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Full transform with start pulses while busy and in DONE.
    t = cyc;
    pulse(1'b1);
    run_to(t + 5);
    pulse(1'b1);
    run_to(t + 41);
    pulse(1'b1);
    run_to(t + 42);
    t = cyc;
    pulse(1'b1);
    run_to(t + 45);

    // Reset mid-transform, then a clean transform.
    t = cyc;
    pulse(1'b1);
    run_to(t + 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to(cyc + 60);
    t = cyc;
    pulse(1'b1);
    run_to(t + 45);

    // Depth sweep on the PIPE=1 and PIPE=7 instances.
    t = cyc;
    pulse(1'b0);
    run_to(t + 66);

    chk("rdq_left", rdq.size(), 0);
    chk("wrq_left", wrq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
